// File: rtl/i2c_master_rw.sv
// rtl/i2c_master_rw.sv - multi-byte I2C master read/write engine with programmable SCL divider
// Optional SCL clock stretching is enabled by defining I2C_CLOCK_STRETCH_EN.
module i2c_master_rw #(
   parameter int CLK_DIV   = 4,
   parameter int MAX_BYTES = 16,
   parameter int LEN_W     = 5
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [6:0]       i_address,
   input  logic             i_rw,
   input  logic [LEN_W-1:0] i_length,
   input  logic [7:0]       i_tx_data,
   input  logic             i_tx_valid,
   output logic             o_tx_ready,
   output logic [7:0]       o_rx_data,
   output logic             o_rx_valid,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_nack,
   input  logic             i_sda_in,
   output logic             o_sda_oe,
   input  logic             i_scl_in,
   output logic             o_scl_oe
);
   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_RACK, S_STOP
   } state_t;

   localparam int QW = $clog2(CLK_DIV);
   localparam logic [QW-1:0]    Q_LAST  = QW'(CLK_DIV - 1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BYTES);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   state_t           r_state, w_next;
   logic [QW-1:0]    r_qcnt;
   logic [1:0]       r_q;
   logic [2:0]       r_bit;
   logic [7:0]       r_shift;
   logic [LEN_W-1:0] r_remain;
   logic             r_rw, r_ack_bit, r_nack_pend;
   logic             r_busy, r_done, r_nack, r_rx_valid;
   logic [7:0]       r_rx_data;
   logic             w_in_slot, w_stretch, w_tx_req, w_hold, w_sample, w_slot_end;

   assign w_in_slot = (r_state != S_IDLE) && (r_state != S_START);
`ifdef I2C_CLOCK_STRETCH_EN
   assign w_stretch = w_in_slot && (r_q == 2'd2) && !i_scl_in;
`else
   logic w_unused_scl;
   assign w_unused_scl = i_scl_in & w_in_slot;
   assign w_stretch    = 1'b0;
`endif

   // The quarter counter parks on q0 of bit 7 until the write byte is supplied.
   assign w_tx_req   = (r_state == S_WDATA) && (r_bit == 3'd7) && (r_q == 2'd0) && (r_qcnt == '0);
   assign w_hold     = (w_tx_req && !i_tx_valid) || w_stretch;
   assign w_sample   = !w_hold && (r_q == 2'd2) && (r_qcnt == Q_LAST);
   assign w_slot_end = !w_hold && (r_q == 2'd3) && (r_qcnt == Q_LAST);

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = S_START;
         S_START: if (w_slot_end) w_next = S_ADDR;
         S_ADDR:  if (w_slot_end && r_bit == 3'd0) w_next = S_AACK;
         S_AACK:
            if (w_slot_end) begin
               if (r_ack_bit || r_remain == '0) w_next = S_STOP;
               else if (r_rw)                   w_next = S_RDATA;
               else                             w_next = S_WDATA;
            end
         S_WDATA: if (w_slot_end && r_bit == 3'd0) w_next = S_WACK;
         S_WACK:  if (w_slot_end) w_next = (r_ack_bit || r_remain <= LEN_ONE) ? S_STOP : S_WDATA;
         S_RDATA: if (w_slot_end && r_bit == 3'd0) w_next = S_RACK;
         S_RACK:  if (w_slot_end) w_next = (r_remain <= LEN_ONE) ? S_STOP : S_RDATA;
         S_STOP:  if (w_slot_end) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_qcnt      <= '0;
         r_q         <= 2'd0;
         r_bit       <= 3'd7;
         r_shift     <= 8'h00;
         r_remain    <= '0;
         r_rw        <= 1'b0;
         r_ack_bit   <= 1'b0;
         r_nack_pend <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_nack      <= 1'b0;
         r_rx_valid  <= 1'b0;
         r_rx_data   <= 8'h00;
      end else begin
         r_done     <= 1'b0;
         r_rx_valid <= 1'b0;
         if (r_state == S_IDLE) begin
            r_qcnt <= '0;
            r_q    <= 2'd0;
            r_bit  <= 3'd7;
            if (i_start) begin
               r_shift     <= {i_address, i_rw};
               r_rw        <= i_rw;
               r_remain    <= (i_length > LEN_MAX) ? LEN_MAX : i_length;
               r_busy      <= 1'b1;
               r_nack      <= 1'b0;
               r_nack_pend <= 1'b0;
            end
         end else begin
            if (!w_hold) begin
               if (r_qcnt == Q_LAST) begin
                  r_qcnt <= '0;
                  r_q    <= r_q + 2'd1;
               end else begin
                  r_qcnt <= r_qcnt + 1'b1;
               end
            end
            if (w_tx_req && i_tx_valid) r_shift <= i_tx_data;
            if (w_sample) begin
               r_ack_bit <= i_sda_in;
               if (r_state == S_RDATA) begin
                  r_shift <= {r_shift[6:0], i_sda_in};
                  if (r_bit == 3'd0) begin
                     r_rx_data  <= {r_shift[6:0], i_sda_in};
                     r_rx_valid <= 1'b1;
                  end
               end
            end
            if (w_slot_end) begin
               case (r_state)
                  S_ADDR, S_WDATA: begin
                     r_bit   <= r_bit - 3'd1;
                     r_shift <= {r_shift[6:0], 1'b0};
                  end
                  S_RDATA: r_bit <= r_bit - 3'd1;
                  S_AACK:  r_nack_pend <= r_ack_bit;
                  S_WACK: begin
                     r_nack_pend <= r_ack_bit;
                     if (!r_ack_bit && r_remain != '0) r_remain <= r_remain - 1'b1;
                  end
                  S_RACK: if (r_remain != '0) r_remain <= r_remain - 1'b1;
                  S_STOP: begin
                     r_busy <= 1'b0;
                     r_done <= 1'b1;
                     r_nack <= r_nack_pend;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // SCL is pulled low in q0-q1 of every bit slot; SDA only ever moves while SCL is low.
   always_comb begin
      o_sda_oe   = 1'b0;
      o_scl_oe   = 1'b0;
      o_tx_ready = w_tx_req;
      case (r_state)
         S_START: begin
            o_sda_oe = 1'b1;
            o_scl_oe = r_q[1];
         end
         S_ADDR, S_WDATA: begin
            o_sda_oe = !r_shift[7];
            o_scl_oe = !r_q[1];
         end
         S_AACK, S_WACK, S_RDATA: o_scl_oe = !r_q[1];
         S_RACK: begin
            o_sda_oe = (r_remain > LEN_ONE);
            o_scl_oe = !r_q[1];
         end
         S_STOP: begin
            o_sda_oe = !r_q[1];
            o_scl_oe = (r_q == 2'd0);
         end
         default: ;
      endcase
   end

   assign o_rx_data  = r_rx_data;
   assign o_rx_valid = r_rx_valid;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_nack     = r_nack;
endmodule
